// File: rtl/inst_fetch_bridge_if.sv
// SRAM-like instruction bus between the fetch bridge and the memory side.
// Two-phase transaction: address accepted by addr_ok, read data returned with data_ok.
interface inst_fetch_bridge_if;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_addr_ok_i;
  logic        bus_data_ok_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o,
    output bus_addr_o,
    input  bus_addr_ok_i,
    input  bus_data_ok_i,
    input  bus_rdata_i
  );

  modport slave (
    input  bus_req_o,
    input  bus_addr_o,
    output bus_addr_ok_i,
    output bus_data_ok_i,
    output bus_rdata_i
  );
endinterface

// File: rtl/inst_fetch_bridge.sv
// Fetch bridge: one-entry address-tagged instruction buffer in front of a variable-latency bus.
// Misses stall the core; timeouts and misaligned PCs return a NOP.
module inst_fetch_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] NOP_INST    = 32'h0340_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       core_ce_i,
  input  logic [31:0]                core_addr_i,
  output logic [31:0]                core_inst_o,
  output logic                       core_stall_o,
  output logic                       fetch_err_o,
  output logic                       align_err_o,
  inst_fetch_bridge_if.master        bus
);

  localparam int unsigned     CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0]   TMO_MAX  = CW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic            buf_valid_q, buf_valid_d;
  logic [31:0]     buf_addr_q, buf_addr_d;
  logic [31:0]     buf_data_q, buf_data_d;
  logic [31:0]     req_addr_q, req_addr_d;
  logic            bus_req_q, bus_req_d;
  logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            fetch_err_d;
  logic            hit;
  logic            done;

  assign align_err_o  = core_ce_i & (core_addr_i[1:0] != 2'b00);
  assign hit          = buf_valid_q & (buf_addr_q == core_addr_i) & ~align_err_o;
  assign core_stall_o = core_ce_i & ~hit & ~align_err_o;

  assign bus.bus_req_o  = bus_req_q;
  assign bus.bus_addr_o = req_addr_q;

  always_comb begin
    core_inst_o = '0;
    if (core_ce_i) begin
      if (align_err_o)
        core_inst_o = NOP_INST;
      else if (hit)
        core_inst_o = buf_data_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    req_addr_d  = req_addr_q;
    bus_req_d   = 1'b0;
    tmo_cnt_d   = tmo_cnt_q;
    fetch_err_d = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (core_stall_o) begin
          req_addr_d = core_addr_i;
          tmo_cnt_d  = '0;
          bus_req_d  = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        // data_ok only counts in REQ when the address is accepted in the same cycle
        done = (state_q == S_REQ) ? (bus.bus_addr_ok_i & bus.bus_data_ok_i)
                                  : bus.bus_data_ok_i;
        if (done) begin
          buf_valid_d = 1'b1;
          buf_addr_d  = req_addr_q;
          buf_data_d  = bus.bus_rdata_i;
          state_d     = S_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          buf_valid_d = 1'b1;
          buf_addr_d  = req_addr_q;
          buf_data_d  = NOP_INST;
          fetch_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          if (tmo_cnt_q != TMO_MAX)
            tmo_cnt_d = tmo_cnt_q + CW'(1);
          if (state_q == S_REQ) begin
            if (bus.bus_addr_ok_i)
              state_d = S_WAIT;
            else
              bus_req_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      req_addr_q  <= '0;
      bus_req_q   <= 1'b0;
      tmo_cnt_q   <= '0;
      fetch_err_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      req_addr_q  <= req_addr_d;
      bus_req_q   <= bus_req_d;
      tmo_cnt_q   <= tmo_cnt_d;
      fetch_err_o <= fetch_err_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Scoreboard bench for inst_fetch_bridge: directed fetches, a latency-programmable bus slave,
// and monitors that check delivered instructions and accepted bus addresses against queues.
module tb_inst_fetch_bridge;

  localparam int unsigned TMO = 8;
  localparam logic [31:0] NOP = 32'h0340_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        stall;
  logic        ferr;
  logic        aerr;

  inst_fetch_bridge_if bus_if();

  inst_fetch_bridge #(.TIMEOUT_CYC(TMO), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_ce_i    (ce),
    .core_addr_i  (addr),
    .core_inst_o  (inst),
    .core_stall_o (stall),
    .fetch_err_o  (ferr),
    .align_err_o  (aerr),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          err_pulses = 0;
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_bus_q[$];
  int          addr_lat = 0;
  int          data_lat = 0;
  bit          never_accept = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h1C00_0000: return 32'h0280_0421;
      32'h1C00_0004: return 32'h0280_0842;
      32'h1C00_0010: return 32'h0280_0C63;
      32'h1C00_0014: return 32'h0280_1084;
      32'h1C00_0018: return 32'h0280_1CE7;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Bus slave and bus-address monitor
  initial begin
    int          ph;
    int          cnt;
    int          dcnt;
    logic [31:0] acc_addr;
    ph = 0; cnt = 0; dcnt = 0; acc_addr = '0;
    bus_if.bus_addr_ok_i = 1'b0;
    bus_if.bus_data_ok_i = 1'b0;
    bus_if.bus_rdata_i   = 32'hBAD0_0000;
    forever begin
      @(negedge clk);
      bus_if.bus_addr_ok_i = 1'b0;
      bus_if.bus_data_ok_i = 1'b0;
      bus_if.bus_rdata_i   = 32'hBAD0_0000;
      if (!rst) begin
        ph = 0; cnt = 0;
      end else if (ph == 0) begin
        if (bus_if.bus_req_o && !never_accept) begin
          if (cnt == addr_lat) begin
            cnt = 0;
            acc_addr = bus_if.bus_addr_o;
            bus_if.bus_addr_ok_i = 1'b1;
            if (exp_bus_q.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL unexpected_bus_req: actual=%h required=none", acc_addr);
            end else
              chk("bus_addr", acc_addr, exp_bus_q.pop_front());
            if (data_lat == 0) begin
              bus_if.bus_data_ok_i = 1'b1;
              bus_if.bus_rdata_i   = mem_word(acc_addr);
            end else begin
              ph = 1; dcnt = 1;
            end
          end else
            cnt++;
        end
      end else begin
        if (dcnt == data_lat) begin
          bus_if.bus_data_ok_i = 1'b1;
          bus_if.bus_rdata_i   = mem_word(acc_addr);
          ph = 0;
        end else
          dcnt++;
      end
    end
  end

  // Core-side monitor: one comparison per new delivery (ce & ~stall rising)
  initial begin
    logic prev_d;
    logic d;
    prev_d = 1'b0;
    forever begin
      @(negedge clk);
      if (ferr === 1'b1) err_pulses++;
      d = (ce === 1'b1) && (stall === 1'b0);
      if (d && !prev_d) begin
        if (exp_inst_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_delivery: actual=%h required=none", inst);
        end else
          chk("core_inst", inst, exp_inst_q.pop_front());
      end
      prev_d = d;
    end
  end

  task automatic drive(input logic [31:0] a);
    @(posedge clk); #1;
    ce   = 1'b1;
    addr = a;
  endtask

  task automatic wait_deliver(input int exp_stall);
    int n;
    n = 0;
    @(negedge clk);
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (stall) begin
      n_cmp++; n_bad++;
      $display("FAIL deliver_timeout: actual=stalled required=delivered");
    end else if (exp_stall >= 0)
      chk("stall_cycles", 32'(n), 32'(exp_stall));
  endtask

  task automatic release_ce();
    @(posedge clk); #1;
    ce = 1'b0;
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: actual=running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; ce = 1'b0; addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_bus_req",   {31'b0, bus_if.bus_req_o}, 32'd0);
    chk("rst_bus_addr",  bus_if.bus_addr_o, 32'd0);
    chk("rst_fetch_err", {31'b0, ferr}, 32'd0);
    chk("rst_inst",      inst, 32'd0);
    chk("rst_stall",     {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // 1: cold miss, both oks in first REQ cycle
    addr_lat = 0; data_lat = 0;
    exp_bus_q.push_back(32'h1C00_0000);
    exp_inst_q.push_back(32'h0280_0421);
    drive(32'h1C00_0000);
    wait_deliver(2);
    chk("align_err_clean", {31'b0, aerr}, 32'd0);
    release_ce();

    // 2a: repeat address hits with no bus activity
    exp_inst_q.push_back(32'h0280_0421);
    drive(32'h1C00_0000);
    wait_deliver(0);
    chk("hit_no_bus_req", {31'b0, bus_if.bus_req_o}, 32'd0);
    release_ce();

    // 2b: addr_ok after 3 REQ cycles, data_ok 2 cycles later
    addr_lat = 3; data_lat = 2;
    exp_bus_q.push_back(32'h1C00_0004);
    exp_inst_q.push_back(32'h0280_0842);
    drive(32'h1C00_0004);
    wait_deliver(7);
    release_ce();

    // 3: bus never accepts -> timeout NOP
    never_accept = 1'b1;
    exp_inst_q.push_back(NOP);
    drive(32'h1C00_0008);
    wait_deliver(9);
    chk("fetch_err_pulse",   {31'b0, ferr}, 32'd1);
    chk("tmo_bus_req_drop",  {31'b0, bus_if.bus_req_o}, 32'd0);
    release_ce();
    @(negedge clk);
    chk("fetch_err_one_cyc", {31'b0, ferr}, 32'd0);
    never_accept = 1'b0;

    // 4: misaligned PC
    exp_inst_q.push_back(NOP);
    drive(32'h1C00_0002);
    wait_deliver(0);
    chk("align_err",         {31'b0, aerr}, 32'd1);
    chk("align_no_bus_req",  {31'b0, bus_if.bus_req_o}, 32'd0);
    @(negedge clk);
    chk("align_no_bus_req2", {31'b0, bus_if.bus_req_o}, 32'd0);
    release_ce();

    // 5: address change during WAIT; old completes, new refetched
    addr_lat = 0; data_lat = 3;
    exp_bus_q.push_back(32'h1C00_0010);
    exp_bus_q.push_back(32'h1C00_0014);
    exp_inst_q.push_back(32'h0280_1084);
    drive(32'h1C00_0010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    addr = 32'h1C00_0014;
    wait_deliver(-1);
    release_ce();

    // 6: reset during WAIT, buffered entry invalidated, same address refetched
    data_lat = 4;
    exp_bus_q.push_back(32'h1C00_0018);
    exp_bus_q.push_back(32'h1C00_0018);
    exp_inst_q.push_back(32'h0280_1CE7);
    drive(32'h1C00_0018);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst  = 1'b0;
    addr = 32'h1C00_0014;
    #1;
    chk("rst_mid_bus_req",   {31'b0, bus_if.bus_req_o}, 32'd0);
    chk("rst_mid_bus_addr",  bus_if.bus_addr_o, 32'd0);
    chk("rst_mid_buf_inval", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    rst  = 1'b1;
    addr = 32'h1C00_0018;
    wait_deliver(-1);
    release_ce();

    repeat (3) @(negedge clk);
    chk("inst_q_drained", 32'(exp_inst_q.size()), 32'd0);
    chk("bus_q_drained",  32'(exp_bus_q.size()), 32'd0);
    chk("fetch_err_count", 32'(err_pulses), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
